relprime_engine: RTL and testbench
==================================

Name: relprime_engine

Overview:
- Parametrised hardware golden model of the relprime program: for input n, finds the smallest m >= 2 with gcd(m, n) == 1.
- Sits beside the integration processor on the FPGA/sim top level.
- Compares its own answer against the processor's FPGAOut, replacing hand-coded expected values such as 0x000b for n = 5040.
- Generalises the single fixed 16-bit check to any width, adds a cycle budget/timeout, and adds an optional compare mode.

Parameters:
- WIDTH, 16: width of n, m and the result.
- CYC_W, 24: width of the cycle counter.
- MAX_CYCLES, 24'hFFFFFF: cycle budget; reaching it aborts with err.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- n_in  input  WIDTH  operand n; captured when start is accepted.
- check_en  input  1  compare mode enable; captured with n_in.
- dut_value  input  WIDTH  processor result (FPGAOut); sampled in DONE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  m; held until the next accepted start.
- err  output  1  n == 0, m overflow, or timeout; held with result.
- match  output  1  check_en && !err && dut_value == result; valid with done, held.
- cycles  output  CYC_W  count of clocks spent in LOAD/GCD/NEXT; held.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - Next state IDLE.
  - busy, done, err and match go to 0; result = 0; cycles = 0.
  - Internal a, b, m, n registers go to 0.
  - An aborted operation produces no done.
- IDLE:
  - With start = 1: capture n_in and check_en, set m = 2, clear cycles, err and match.
  - If n_in == 0, go to DONE with err = 1 and result = 0.
  - Otherwise go to LOAD.
- LOAD: a = n, b = m; go to GCD.
- GCD, one Euclid subtraction step per cycle:
  - a > b: a -= b.
  - b > a: b -= a.
  - a == b and a == 1: result = m, go to DONE.
  - a == b and a != 1: go to NEXT.
- NEXT:
  - If m == {WIDTH{1}}: err = 1, result = 0, go to DONE.
  - Otherwise m = m + 1 and go to LOAD.
- Cycle counting:
  - cycles increments once per cycle spent in LOAD, GCD or NEXT, saturating at MAX_CYCLES.
  - When the count reaches MAX_CYCLES in any of those states: err = 1, result = 0, go to DONE.
- DONE:
  - done = 1 for exactly this cycle; match computed from the current dut_value.
  - Next state IDLE.
  - result, err, match and cycles are held until the next accepted start.
- Handshake:
  - start in any state other than IDLE is ignored: not queued, no effect.
  - start may be held high. A new operation begins on the cycle after DONE if start is still high, because IDLE samples it.
- Arithmetic:
  - All compares are unsigned, WIDTH bits.
  - Subtraction never underflows, since only the larger operand is reduced.
- Latency examples:
  - n = 1: LOAD, GCD(sub), GCD(eq), then DONE; cycles = 3, result = 2.
  - n = 2: m = 2 fails, m = 3 passes; result = 3.

Test Plan:
- Default parameters, n_in = 5040, check_en = 1, dut_value = 16'h000b: one done pulse, result = 16'h000b, err = 0, match = 1, busy low after done.
- n_in = 30030, check_en = 1, dut_value = 16'h000b: result = 17 (16'h0011), match = 0, err = 0.
- n_in = 1: result = 2, cycles = 3, done exactly 4 clocks after the start cycle. Then n_in = 0: done on the cycle after start, err = 1, result = 0.
- MAX_CYCLES = 10, n_in = 5040: err = 1, result = 0, cycles = 10, match = 0 even with dut_value = 0.
- Start n_in = 5040; raise start with n_in = 7 while busy, then assert reset for 1 cycle mid-GCD:
  - the start is ignored;
  - after reset, all outputs are 0 and no done pulse appears;
  - a fresh start with n_in = 7 gives result = 2.
- WIDTH = 8, n_in = 8'hFF (255): result = 2. Then back-to-back starts with start held high: two done pulses, each followed by exactly one IDLE cycle.

Source files
------------

// File: rtl/relprime_engine.sv
// Hardware golden model of the relprime program: finds the smallest m >= 2
// with gcd(m, n) == 1 by repeated subtraction, and optionally checks it against a processor result.
module relprime_engine #(
    parameter int unsigned             WIDTH      = 16,
    parameter int unsigned             CYC_W      = 24,
    parameter logic [CYC_W-1:0]        MAX_CYCLES = 24'hFFFFFF
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic             check_en,
    input  logic [WIDTH-1:0] dut_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             match,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [2:0] {IDLE, LOAD, GCD, NEXT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b, m, n;
    logic             check_q;
    logic             match_q;
    logic [CYC_W-1:0] cyc_inc;
    logic             timeout;
    logic             match_now;

    assign cyc_inc   = cycles + 1'b1;
    assign timeout   = (cyc_inc >= MAX_CYCLES);
    assign match_now = check_q && !err && (dut_value == result);
    // match follows the live dut_value during DONE, then holds what DONE saw
    assign match     = (state == DONE) ? match_now : match_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            match_q <= 1'b0;
            check_q <= 1'b0;
            result  <= '0;
            cycles  <= '0;
            a       <= '0;
            b       <= '0;
            m       <= '0;
            n       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n       <= n_in;
                        check_q <= check_en;
                        m       <= WIDTH'(2);
                        cycles  <= '0;
                        err     <= 1'b0;
                        match_q <= 1'b0;
                        result  <= '0;
                        busy    <= 1'b1;
                        if (n_in == '0) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD, GCD, NEXT: begin
                    // budget exhaustion takes priority over whatever the state would do
                    cycles <= timeout ? MAX_CYCLES : cyc_inc;
                    if (timeout) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (state == LOAD) begin
                        a     <= n;
                        b     <= m;
                        state <= GCD;
                    end else if (state == GCD) begin
                        if (a > b) begin
                            a <= a - b;
                        end else if (b > a) begin
                            b <= b - a;
                        end else if (a == WIDTH'(1)) begin
                            result <= m;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        if (m == '1) begin
                            err    <= 1'b1;
                            result <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            m     <= m + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    match_q <= match_now;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relprime_engine.sv
// Directed bench for relprime_engine: default, short-budget and 8-bit instances.
module tb_relprime_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // default instance
    logic        st_a = 0, ce_a = 0;
    logic [15:0] n_a = '0, dv_a = '0;
    logic        busy_a, done_a, err_a, match_a;
    logic [15:0] res_a;
    logic [23:0] cyc_a;

    // MAX_CYCLES = 10 instance
    logic        st_t = 0, ce_t = 0;
    logic [15:0] n_t = '0, dv_t = '0;
    logic        busy_t, done_t, err_t, match_t;
    logic [15:0] res_t;
    logic [23:0] cyc_t;

    // WIDTH = 8 instance
    logic        st_w = 0, ce_w = 0;
    logic [7:0]  n_w = '0, dv_w = '0;
    logic        busy_w, done_w, err_w, match_w;
    logic [7:0]  res_w;
    logic [23:0] cyc_w;

    relprime_engine u_a (
        .CLK(clk), .reset(rst), .start(st_a), .n_in(n_a), .check_en(ce_a),
        .dut_value(dv_a), .busy(busy_a), .done(done_a), .result(res_a),
        .err(err_a), .match(match_a), .cycles(cyc_a)
    );

    relprime_engine #(.MAX_CYCLES(24'd10)) u_t (
        .CLK(clk), .reset(rst), .start(st_t), .n_in(n_t), .check_en(ce_t),
        .dut_value(dv_t), .busy(busy_t), .done(done_t), .result(res_t),
        .err(err_t), .match(match_t), .cycles(cyc_t)
    );

    relprime_engine #(.WIDTH(8)) u_w (
        .CLK(clk), .reset(rst), .start(st_w), .n_in(n_w), .check_en(ce_w),
        .dut_value(dv_w), .busy(busy_w), .done(done_w), .result(res_w),
        .err(err_w), .match(match_w), .cycles(cyc_w)
    );

    // Pulse start on the default instance and wait for done; lat counts edges from the start cycle.
    task automatic run_a(input logic [15:0] nv, input logic ce, input logic [15:0] dv,
                         input int unsigned bound, output int unsigned lat, output bit ok);
        st_a = 1'b1; n_a = nv; ce_a = ce; dv_a = dv;
        lat = 0; ok = 0;
        while (lat < bound) begin
            @(posedge clk); #1;
            lat++;
            st_a = 1'b0;
            if (done_a) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({busy_a, done_a, err_a, match_a} !== 4'b0 || res_a !== 16'h0 || cyc_a !== 24'h0) begin
            failures++;
            $display("FAIL reset_a busy=%b done=%b err=%b match=%b result=%h cycles=%0d required all zero",
                     busy_a, done_a, err_a, match_a, res_a, cyc_a);
        end
        checks++;
        if ({busy_t, done_t, err_t, match_t} !== 4'b0 || res_t !== 16'h0 || cyc_t !== 24'h0) begin
            failures++;
            $display("FAIL reset_t busy=%b done=%b err=%b result=%h required all zero", busy_t, done_t, err_t, res_t);
        end
        checks++;
        if ({busy_w, done_w, err_w, match_w} !== 4'b0 || res_w !== 8'h0 || cyc_w !== 24'h0) begin
            failures++;
            $display("FAIL reset_w busy=%b done=%b err=%b result=%h required all zero", busy_w, done_w, err_w, res_w);
        end
    endtask

    task automatic test_5040();
        int unsigned lat; bit ok;
        run_a(16'd5040, 1'b1, 16'h000b, 80000, lat, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL n5040_done timed out after %0d cycles", lat); end
        checks++;
        if ({res_a, err_a, match_a, busy_a} !== {16'h000b, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL n5040_result result=%h err=%b match=%b busy=%b required 000b 0 1 1",
                     res_a, err_a, match_a, busy_a);
        end
        @(posedge clk); #1;
        checks++;
        if ({done_a, busy_a, match_a} !== 3'b001 || res_a !== 16'h000b) begin
            failures++;
            $display("FAIL n5040_after done=%b busy=%b match=%b result=%h required 0 0 1 000b",
                     done_a, busy_a, match_a, res_a);
        end
    endtask

    task automatic test_30030();
        int unsigned lat; bit ok;
        run_a(16'd30030, 1'b1, 16'h000b, 80000, lat, ok);
        checks++;
        if (!ok || res_a !== 16'h0011 || err_a !== 1'b0 || match_a !== 1'b0) begin
            failures++;
            $display("FAIL n30030 ok=%b result=%h err=%b match=%b required 1 0011 0 0", ok, res_a, err_a, match_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_small();
        int unsigned lat; bit ok;
        run_a(16'd1, 1'b0, 16'h0, 20, lat, ok);
        checks++;
        if (!ok || lat !== 4) begin
            failures++; $display("FAIL n1_latency got=%0d ok=%b required 4", lat, ok);
        end
        checks++;
        if (res_a !== 16'd2 || cyc_a !== 24'd3 || err_a !== 1'b0 || match_a !== 1'b0) begin
            failures++;
            $display("FAIL n1_result result=%0d cycles=%0d err=%b match=%b required 2 3 0 0", res_a, cyc_a, err_a, match_a);
        end
        @(posedge clk); #1;
        run_a(16'd0, 1'b1, 16'h0, 20, lat, ok);
        checks++;
        if (!ok || lat !== 1) begin
            failures++; $display("FAIL n0_latency got=%0d ok=%b required 1", lat, ok);
        end
        checks++;
        if (err_a !== 1'b1 || res_a !== 16'h0 || match_a !== 1'b0 || cyc_a !== 24'd0) begin
            failures++;
            $display("FAIL n0_result err=%b result=%h match=%b cycles=%0d required 1 0 0 0", err_a, res_a, match_a, cyc_a);
        end
        @(posedge clk); #1;
        run_a(16'd2, 1'b1, 16'd3, 40, lat, ok);
        checks++;
        if (!ok || res_a !== 16'd3 || cyc_a !== 24'd7 || match_a !== 1'b1) begin
            failures++;
            $display("FAIL n2_result ok=%b result=%0d cycles=%0d match=%b required 1 3 7 1", ok, res_a, cyc_a, match_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int unsigned lat; bit ok;
        st_t = 1'b1; n_t = 16'd5040; ce_t = 1'b1; dv_t = 16'h0;
        lat = 0; ok = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            st_t = 1'b0;
            if (done_t) begin ok = 1; break; end
        end
        checks++;
        if (!ok || lat !== 11) begin
            failures++; $display("FAIL timeout_latency got=%0d ok=%b required 11", lat, ok);
        end
        checks++;
        if (err_t !== 1'b1 || res_t !== 16'h0 || cyc_t !== 24'd10 || match_t !== 1'b0) begin
            failures++;
            $display("FAIL timeout_result err=%b result=%h cycles=%0d match=%b required 1 0 10 0", err_t, res_t, cyc_t, match_t);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_t !== 1'b0 || err_t !== 1'b1 || cyc_t !== 24'd10) begin
            failures++;
            $display("FAIL timeout_hold busy=%b err=%b cycles=%0d required 0 1 10", busy_t, err_t, cyc_t);
        end
    endtask

    task automatic test_reset_midop();
        int unsigned lat; bit ok; bit seen_done; bit seen_busy;
        st_a = 1'b1; n_a = 16'd5040; ce_a = 1'b0; dv_a = 16'h0;
        @(posedge clk); #1 st_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 st_a = 1'b1; n_a = 16'd7;
        repeat (3) @(posedge clk);
        #1 st_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            failures++; $display("FAIL ignored_start busy=%b done=%b required 1 0", busy_a, done_a);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++;
        if ({busy_a, done_a, err_a, match_a} !== 4'b0 || res_a !== 16'h0 || cyc_a !== 24'h0) begin
            failures++;
            $display("FAIL midop_reset busy=%b done=%b err=%b match=%b result=%h cycles=%0d required all zero",
                     busy_a, done_a, err_a, match_a, res_a, cyc_a);
        end
        seen_done = 0; seen_busy = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done_a) seen_done = 1;
            if (busy_a) seen_busy = 1;
        end
        checks++;
        if (seen_done || seen_busy) begin
            failures++; $display("FAIL aborted_quiet done_seen=%b busy_seen=%b required 0 0", seen_done, seen_busy);
        end
        run_a(16'd7, 1'b1, 16'd2, 100, lat, ok);
        checks++;
        if (!ok || res_a !== 16'd2 || cyc_a !== 24'd6 || match_a !== 1'b1 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL n7_fresh ok=%b result=%0d cycles=%0d match=%b err=%b required 1 2 6 1 0",
                     ok, res_a, cyc_a, match_a, err_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_w(input int unsigned bound, output bit ok);
        int unsigned k;
        k = 0; ok = 0;
        while (k < bound) begin
            @(posedge clk); #1;
            k++;
            if (done_w) begin ok = 1; break; end
        end
    endtask

    task automatic test_width8();
        bit ok;
        st_w = 1'b1; n_w = 8'hFF; ce_w = 1'b1; dv_w = 8'd2;
        @(posedge clk); #1 st_w = 1'b0;
        wait_w(1000, ok);
        checks++;
        if (!ok || res_w !== 8'd2 || cyc_w !== 24'd130 || match_w !== 1'b1 || err_w !== 1'b0) begin
            failures++;
            $display("FAIL w8_255 ok=%b result=%0d cycles=%0d match=%b err=%b required 1 2 130 1 0",
                     ok, res_w, cyc_w, match_w, err_w);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        st_w = 1'b1; n_w = 8'hFF; ce_w = 1'b0; dv_w = 8'h0;
        wait_w(1000, ok);
        checks++;
        if (!ok || res_w !== 8'd2) begin
            failures++; $display("FAIL b2b_first ok=%b result=%0d required 1 2", ok, res_w);
        end
        @(posedge clk); #1;
        checks++;
        if (done_w !== 1'b0 || busy_w !== 1'b0) begin
            failures++; $display("FAIL b2b_idle1 done=%b busy=%b required 0 0", done_w, busy_w);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_w !== 1'b1) begin
            failures++; $display("FAIL b2b_restart busy=%b required 1", busy_w);
        end
        wait_w(1000, ok);
        st_w = 1'b0;
        checks++;
        if (!ok || res_w !== 8'd2 || cyc_w !== 24'd130) begin
            failures++; $display("FAIL b2b_second ok=%b result=%0d cycles=%0d required 1 2 130", ok, res_w, cyc_w);
        end
        @(posedge clk); #1;
        checks++;
        if (done_w !== 1'b0 || busy_w !== 1'b0) begin
            failures++; $display("FAIL b2b_idle2 done=%b busy=%b required 0 0", done_w, busy_w);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_w !== 1'b0 || res_w !== 8'd2) begin
            failures++; $display("FAIL b2b_stop busy=%b result=%0d required 0 2", busy_w, res_w);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_small();
        test_5040();
        test_30030();
        test_timeout();
        test_reset_midop();
        test_width8();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
